alu_cmd_sequencer: RTL and testbench

//   Initiator-side driver for the 5-bit shift+ALU datapath (top): accepts operation

---
 rtl/alu_seq_pkg.sv | 23 ++
 rtl/alu_cmd_sequencer_checker.sv | 47 ++++
 rtl/alu_cmd_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer:
// FSM state encoding, ALU control codes and flag bit positions.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // ALU control codes understood by the external shift+ALU datapath.
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;

   // Bit positions inside the 4-bit {N,Z,C,V} flag vector.
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage : alu_seq_pkg

// File: rtl/alu_cmd_sequencer_checker.sv
// Result checker for the ALU command sequencer: flags a captured result
// that differs from the expected value and counts such responses.
// Only instantiated when ALU_SEQ_CHECK_EN is defined.
module alu_seq_checker #(
   parameter int DATA_W = 5,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              capture_i,
   input  logic [DATA_W-1:0] result_i,
   input  logic [DATA_W-1:0] exp_i,
   input  logic              rsp_hs_i,
   output logic              mismatch_o,
   output logic [CNT_W-1:0]  err_count_o
);

   logic             mismatch_q, mismatch_d;
   logic [CNT_W-1:0] err_q, err_d;

   // Next state: compare at capture, count mismatches on the response handshake.
   always_comb begin
      mismatch_d = mismatch_q;
      err_d      = err_q;
      if (capture_i) begin
         mismatch_d = (result_i != exp_i);
      end
      if (rsp_hs_i && mismatch_q && (err_q != {CNT_W{1'b1}})) begin
         err_d = err_q + CNT_W'(1);
      end
   end

   // State registers, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mismatch_q <= 1'b0;
         err_q      <= '0;
      end else begin
         mismatch_q <= mismatch_d;
         err_q      <= err_d;
      end
   end

   assign mismatch_o  = mismatch_q;
   assign err_count_o = err_q;

endmodule : alu_seq_checker

// File: rtl/alu_cmd_sequencer.sv
// Initiator-side driver for the shift+ALU datapath. Accepts one command at a
// time over valid/ready, drives registered operands/controls to the ALU,
// waits SETTLE cycles, captures Result/ALUFlag and returns them over valid/ready.
// Optional feature: define ALU_SEQ_CHECK_EN to compare the captured result
// against cmd_exp (rsp_mismatch, err_count); otherwise both are tied to 0.
module alu_cmd_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DATA_W = 5,
   parameter int SETTLE = 1,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [1:0]        cmd_bshift,
   input  logic              cmd_lorr,
   input  logic [2:0]        cmd_ctl,
   input  logic [DATA_W-1:0] cmd_exp,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [1:0]        alu_bshift,
   output logic              alu_lorr,
   output logic [2:0]        alu_ctl,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [3:0]        alu_flag,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic [3:0]        rsp_flag,
   output logic              rsp_mismatch,
   output logic [CNT_W-1:0]  op_count,
   output logic [CNT_W-1:0]  err_count,
   output logic              busy
);

   // Settle counter only needs to hold values 0..SETTLE.
   localparam int SET_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

   state_e            state_q, state_d;
   logic [SET_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [1:0]        alu_bshift_q, alu_bshift_d;
   logic              alu_lorr_q, alu_lorr_d;
   logic [2:0]        alu_ctl_q, alu_ctl_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
   logic [3:0]        rsp_flag_q, rsp_flag_d;
   logic [CNT_W-1:0]  op_count_q, op_count_d;

   logic accept;
   logic capture;
   logic rsp_hs;

   // Next-state and datapath: IDLE accepts, WAIT counts down and captures, RESP waits for the consumer.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
      state_d      = state_q;
      cnt_d        = cnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_bshift_d = alu_bshift_q;
      alu_lorr_d   = alu_lorr_q;
      alu_ctl_d    = alu_ctl_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_flag_d   = rsp_flag_q;
      op_count_d   = op_count_q;
      accept       = 1'b0;
      capture      = 1'b0;
      rsp_hs       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               accept       = 1'b1;
               alu_a_d      = cmd_a;
               alu_b_d      = cmd_b;
               alu_bshift_d = cmd_bshift;
               alu_lorr_d   = cmd_lorr;
               alu_ctl_d    = cmd_ctl;
               cnt_d        = SET_W'(SETTLE);
               state_d      = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - SET_W'(1);
            if (cnt_q == SET_W'(1)) begin
               capture      = 1'b1;
               rsp_result_d = alu_result;
               rsp_flag_d   = alu_flag;
               rsp_valid_d  = 1'b1;
               state_d      = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_hs      = 1'b1;
               rsp_valid_d = 1'b0;
               op_count_d  = op_count_q + CNT_W'(1);
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; async reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_bshift_q <= '0;
         alu_lorr_q   <= 1'b0;
         alu_ctl_q    <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_flag_q   <= '0;
         op_count_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_bshift_q <= alu_bshift_d;
         alu_lorr_q   <= alu_lorr_d;
         alu_ctl_q    <= alu_ctl_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_flag_q   <= rsp_flag_d;
         op_count_q   <= op_count_d;
      end
   end

   assign cmd_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_bshift = alu_bshift_q;
   assign alu_lorr   = alu_lorr_q;
   assign alu_ctl    = alu_ctl_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_flag   = rsp_flag_q;
   assign op_count   = op_count_q;

`ifdef ALU_SEQ_CHECK_EN
   logic [DATA_W-1:0] exp_q;

   // Expected result is latched with the command so the source may move on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q <= '0;
      end else if (accept) begin
         exp_q <= cmd_exp;
      end
   end

   alu_seq_checker #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_checker (
      .clk         (clk),
      .rst_n       (rst_n),
      .capture_i   (capture),
      .result_i    (alu_result),
      .exp_i       (exp_q),
      .rsp_hs_i    (rsp_hs),
      .mismatch_o  (rsp_mismatch),
      .err_count_o (err_count)
   );
`else
   // Without checking, the expected value and checker strobes have no consumer.
   logic unused_chk;
   assign unused_chk   = ^{cmd_exp, accept, capture, rsp_hs};
   assign rsp_mismatch = 1'b0;
   assign err_count    = '0;
`endif

endmodule : alu_cmd_sequencer

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a behavioural shift+ALU stands in for the
// datapath; one instance with SETTLE=1, a second with SETTLE=3.
module tb_alu_cmd_sequencer;
   import alu_seq_pkg::*;

   localparam int DW = 5;
   localparam int CW = 8;
`ifdef ALU_SEQ_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          cmd_valid = 1'b0, cmd_valid3 = 1'b0;
   logic          rsp_ready = 1'b0, rsp_ready3 = 1'b0;
   logic [DW-1:0] cmd_a = '0, cmd_b = '0, cmd_exp = '0;
   logic [1:0]    cmd_bshift = '0;
   logic          cmd_lorr = 1'b0;
   logic [2:0]    cmd_ctl = '0;

   logic          cmd_ready, rsp_valid, rsp_mismatch, busy, alu_lorr;
   logic [DW-1:0] alu_a, alu_b, alu_result, rsp_result;
   logic [1:0]    alu_bshift;
   logic [2:0]    alu_ctl;
   logic [3:0]    alu_flag, rsp_flag;
   logic [CW-1:0] op_count, err_count;

   logic          cmd_ready3, rsp_valid3, rsp_mismatch3, busy3, alu_lorr3;
   logic [DW-1:0] alu_a3, alu_b3, alu_result3, rsp_result3;
   logic [1:0]    alu_bshift3;
   logic [2:0]    alu_ctl3;
   logic [3:0]    alu_flag3, rsp_flag3;
   logic [CW-1:0] op_count3, err_count3;

   int n_cmp = 0;
   int n_bad = 0;
   int m_ops = 0;
   int m_errs = 0;

   // Behavioural datapath: shift b, then apply the ALU op; returns {N,Z,C,V,result}.
   function automatic logic [8:0] alu_model(input logic [4:0] a, input logic [4:0] b,
                                            input logic [1:0] sh, input logic lorr,
                                            input logic [2:0] ctl);
      logic [4:0] bs, r;
      logic [5:0] wide;
      logic       c, v;
      bs = lorr ? 5'(b << sh) : 5'(b >> sh);
      c = 1'b0;
      v = 1'b0;
      wide = '0;
      case (ctl)
         ALU_ADD: begin
            wide = {1'b0, a} + {1'b0, bs};
            r = wide[4:0];
            c = wide[5];
            v = (a[4] == bs[4]) && (r[4] != a[4]);
         end
         ALU_SUB: begin
            wide = {1'b0, a} - {1'b0, bs};
            r = wide[4:0];
            c = wide[5];
            v = (a[4] != bs[4]) && (r[4] != a[4]);
         end
         ALU_AND: r = a & bs;
         ALU_OR:  r = a | bs;
         default: r = a ^ bs;
      endcase
      return {r[4], (r == 5'd0), c, v, r};
   endfunction

   assign {alu_flag, alu_result}   = alu_model(alu_a, alu_b, alu_bshift, alu_lorr, alu_ctl);
   assign {alu_flag3, alu_result3} = alu_model(alu_a3, alu_b3, alu_bshift3, alu_lorr3, alu_ctl3);

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.DATA_W(DW), .SETTLE(1), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_bshift(cmd_bshift), .cmd_lorr(cmd_lorr),
      .cmd_ctl(cmd_ctl), .cmd_exp(cmd_exp),
      .alu_a(alu_a), .alu_b(alu_b), .alu_bshift(alu_bshift), .alu_lorr(alu_lorr),
      .alu_ctl(alu_ctl), .alu_result(alu_result), .alu_flag(alu_flag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_flag(rsp_flag), .rsp_mismatch(rsp_mismatch),
      .op_count(op_count), .err_count(err_count), .busy(busy)
   );

   alu_cmd_sequencer #(.DATA_W(DW), .SETTLE(3), .CNT_W(CW)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_bshift(cmd_bshift), .cmd_lorr(cmd_lorr),
      .cmd_ctl(cmd_ctl), .cmd_exp(cmd_exp),
      .alu_a(alu_a3), .alu_b(alu_b3), .alu_bshift(alu_bshift3), .alu_lorr(alu_lorr3),
      .alu_ctl(alu_ctl3), .alu_result(alu_result3), .alu_flag(alu_flag3),
      .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
      .rsp_flag(rsp_flag3), .rsp_mismatch(rsp_mismatch3),
      .op_count(op_count3), .err_count(err_count3), .busy(busy3)
   );

   function automatic logic [CW-1:0] exp_ops();
      return CW'(m_ops);
   endfunction

   function automatic logic [CW-1:0] exp_errs();
      return (m_errs > 255) ? 8'hFF : CW'(m_errs);
   endfunction

   // Present a command to the SETTLE=1 instance; returns #1 after the accept edge.
   task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic [1:0] sh,
                        input logic lorr, input logic [2:0] ctl, input logic [4:0] ex);
      int n = 0;
      cmd_a = a; cmd_b = b; cmd_bshift = sh; cmd_lorr = lorr; cmd_ctl = ctl; cmd_exp = ex;
      cmd_valid = 1'b1;
      while (cmd_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (cmd_ready !== 1'b1) begin
         n_cmp++; n_bad++;
         $display("FAIL issue_ready_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   // Count cycles from the accept edge until rsp_valid is seen.
   task automatic wait_rsp(output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1; lat++;
      end while (rsp_valid !== 1'b1 && lat < 50);
      if (rsp_valid !== 1'b1) begin
         n_cmp++; n_bad++;
         $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, lat);
      end
   endtask

   // Complete the response handshake and advance the reference counters.
   task automatic ack(input bit mis);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      m_ops++;
      if (mis) m_errs++;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (rsp_valid !== 1'b0 || rsp_valid3 !== 1'b0) begin n_bad++;
         $display("FAIL reset_rsp_valid: got %b/%b required 0/0", rsp_valid, rsp_valid3); end
      n_cmp++; if ({alu_a, alu_b, alu_bshift, alu_lorr, alu_ctl} !== '0) begin n_bad++;
         $display("FAIL reset_alu_regs: got %h required 0", {alu_a, alu_b, alu_bshift, alu_lorr, alu_ctl}); end
      n_cmp++; if ({rsp_result, rsp_flag, rsp_mismatch} !== '0) begin n_bad++;
         $display("FAIL reset_rsp_regs: got %h required 0", {rsp_result, rsp_flag, rsp_mismatch}); end
      n_cmp++; if (op_count !== '0 || err_count !== '0) begin n_bad++;
         $display("FAIL reset_counters: got %0d/%0d required 0/0", op_count, err_count); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_bad++;
         $display("FAIL reset_idle: cmd_ready=%b busy=%b required 1/0", cmd_ready, busy); end
   endtask

   task automatic test_basic();
      int lat;
      issue(5'd3, 5'd5, 2'd0, 1'b0, ALU_ADD, 5'd8);
      wait_rsp(lat);
      n_cmp++; if (lat != 1) begin n_bad++;
         $display("FAIL basic_latency: got %0d required 1", lat); end
      n_cmp++; if (rsp_result !== 5'd8) begin n_bad++;
         $display("FAIL basic_result: got %0d required 8", rsp_result); end
      n_cmp++; if (rsp_flag[FLAG_Z] !== 1'b0) begin n_bad++;
         $display("FAIL basic_zflag: got %b required 0", rsp_flag[FLAG_Z]); end
      ack(1'b0);
      n_cmp++; if (op_count !== 8'd1) begin n_bad++;
         $display("FAIL basic_op_count: got %0d required 1", op_count); end
      n_cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_bad++;
         $display("FAIL basic_return_idle: rsp_valid=%b cmd_ready=%b required 0/1", rsp_valid, cmd_ready); end
   endtask

   task automatic test_hold();
      int lat;
      logic [3:0] f0;
      issue(5'd5, 5'd5, 2'd0, 1'b0, ALU_SUB, 5'd0);
      wait_rsp(lat);
      n_cmp++; if (rsp_result !== 5'd0 || rsp_flag[FLAG_Z] !== 1'b1) begin n_bad++;
         $display("FAIL hold_sub_zero: result=%0d Z=%b required 0/1", rsp_result, rsp_flag[FLAG_Z]); end
      f0 = rsp_flag;
      // A competing command during RESP must be ignored.
      cmd_a = 5'd7; cmd_b = 5'd1; cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (rsp_valid !== 1'b1 || rsp_result !== 5'd0 || rsp_flag !== f0 || cmd_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_stable_%0d: valid=%b result=%0d flag=%h ready=%b required 1/0/%h/0",
                     i, rsp_valid, rsp_result, rsp_flag, cmd_ready, f0);
         end
      end
      n_cmp++; if (alu_a !== 5'd5) begin n_bad++;
         $display("FAIL hold_alu_a_kept: got %0d required 5", alu_a); end
      cmd_valid = 1'b0;
      ack(1'b0);
      n_cmp++; if (op_count !== exp_ops()) begin n_bad++;
         $display("FAIL hold_op_count: got %0d required %0d", op_count, exp_ops()); end
   endtask

   task automatic test_shift();
      int lat;
      issue(5'd2, 5'd2, 2'd2, 1'b1, ALU_ADD, 5'd10);
      wait_rsp(lat);
      n_cmp++; if (rsp_result !== 5'd10) begin n_bad++;
         $display("FAIL shift_left: got %0d required 10", rsp_result); end
      ack(1'b0);
      issue(5'd2, 5'd2, 2'd2, 1'b0, ALU_ADD, 5'd2);
      wait_rsp(lat);
      n_cmp++; if (rsp_result !== 5'd2) begin n_bad++;
         $display("FAIL shift_right: got %0d required 2", rsp_result); end
      n_cmp++; if (alu_bshift !== 2'd2 || alu_lorr !== 1'b0) begin n_bad++;
         $display("FAIL shift_alu_ctrl: bshift=%0d lorr=%b required 2/0", alu_bshift, alu_lorr); end
      ack(1'b0);
   endtask

   task automatic test_settle3();
      logic [8:0] m;
      m = alu_model(5'd4, 5'd1, 2'd0, 1'b0, ALU_ADD);
      cmd_a = 5'd4; cmd_b = 5'd1; cmd_bshift = 2'd0; cmd_lorr = 1'b0; cmd_ctl = ALU_ADD;
      cmd_exp = 5'd5;
      cmd_valid3 = 1'b1;
      n_cmp++; if (cmd_ready3 !== 1'b1) begin n_bad++;
         $display("FAIL settle3_ready: got %b required 1", cmd_ready3); end
      @(posedge clk); #1;                    // accept edge E0
      cmd_a = 5'd9; cmd_b = 5'd9;            // second command held during WAIT
      for (int e = 1; e <= 3; e++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (rsp_valid3 !== (e == 3) || cmd_ready3 !== 1'b0 || busy3 !== 1'b1) begin
            n_bad++;
            $display("FAIL settle3_edge_%0d: rsp_valid=%b ready=%b busy=%b required %b/0/1",
                     e, rsp_valid3, cmd_ready3, busy3, (e == 3));
         end
      end
      n_cmp++; if (rsp_result3 !== 5'd5 || rsp_flag3 !== m[8:5] || alu_a3 !== 5'd4) begin n_bad++;
         $display("FAIL settle3_capture: result=%0d flag=%h alu_a=%0d required 5/%h/4",
                  rsp_result3, rsp_flag3, alu_a3, m[8:5]); end
      cmd_valid3 = 1'b0;
      rsp_ready3 = 1'b1;
      @(posedge clk); #1;
      rsp_ready3 = 1'b0;
      n_cmp++; if (op_count3 !== 8'd1 || err_count3 !== 8'd0 || rsp_mismatch3 !== 1'b0) begin n_bad++;
         $display("FAIL settle3_counts: op=%0d err=%0d mis=%b required 1/0/0",
                  op_count3, err_count3, rsp_mismatch3); end
   endtask

   task automatic test_check();
      int lat;
      issue(5'd8, 5'd1, 2'd0, 1'b0, ALU_AND, 5'd5);
      wait_rsp(lat);
      n_cmp++; if (rsp_result !== 5'd0 || rsp_mismatch !== CHK_EN) begin n_bad++;
         $display("FAIL check_mismatch: result=%0d mis=%b required 0/%b", rsp_result, rsp_mismatch, CHK_EN); end
      ack(CHK_EN);
      n_cmp++; if (err_count !== exp_errs()) begin n_bad++;
         $display("FAIL check_err_count: got %0d required %0d", err_count, exp_errs()); end
      issue(5'd8, 5'd1, 2'd0, 1'b0, ALU_AND, 5'd0);
      wait_rsp(lat);
      n_cmp++; if (rsp_mismatch !== 1'b0) begin n_bad++;
         $display("FAIL check_match: mis=%b required 0", rsp_mismatch); end
      ack(1'b0);
      n_cmp++; if (err_count !== exp_errs()) begin n_bad++;
         $display("FAIL check_err_hold: got %0d required %0d", err_count, exp_errs()); end
   endtask

   task automatic test_random();
      int lat;
      logic [4:0] a, b, ex;
      logic [1:0] sh;
      logic       lorr;
      logic [2:0] ctl;
      logic [8:0] m;
      bit         mis;
      for (int i = 0; i < 40; i++) begin
         a = 5'($urandom); b = 5'($urandom); sh = 2'($urandom); lorr = 1'($urandom);
         ctl = 3'($urandom_range(0, 4));
         m = alu_model(a, b, sh, lorr, ctl);
         ex = ($urandom_range(0, 1) == 1) ? m[4:0] : 5'($urandom);
         mis = CHK_EN && (ex != m[4:0]);
         issue(a, b, sh, lorr, ctl, ex);
         wait_rsp(lat);
         n_cmp++;
         if (lat != 1 || rsp_result !== m[4:0] || rsp_flag !== m[8:5] || rsp_mismatch !== mis) begin
            n_bad++;
            $display("FAIL rand_rsp_%0d: lat=%0d result=%h flag=%h mis=%b required 1/%h/%h/%b",
                     i, lat, rsp_result, rsp_flag, rsp_mismatch, m[4:0], m[8:5], mis);
         end
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         ack(mis);
         n_cmp++;
         if (op_count !== exp_ops() || err_count !== exp_errs() || cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rand_counts_%0d: op=%0d err=%0d ready=%b required %0d/%0d/1",
                     i, op_count, err_count, cmd_ready, exp_ops(), exp_errs());
         end
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      issue(5'd6, 5'd3, 2'd0, 1'b0, ALU_OR, 5'd1);   // now in WAIT
      n_cmp++; if (busy !== 1'b1) begin n_bad++;
         $display("FAIL midrst_in_wait: busy=%b required 1", busy); end
      rst_n = 1'b0;
      m_ops = 0;
      m_errs = 0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (rsp_valid !== 1'b0 || op_count !== '0 || err_count !== '0 || alu_a !== '0) begin n_bad++;
         $display("FAIL midrst_cleared: valid=%b op=%0d err=%0d alu_a=%0d required 0/0/0/0",
                  rsp_valid, op_count, err_count, alu_a); end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || op_count !== '0) begin n_bad++;
         $display("FAIL midrst_after: valid=%b ready=%b op=%0d required 0/1/0", rsp_valid, cmd_ready, op_count); end
      issue(5'd6, 5'd3, 2'd0, 1'b0, ALU_OR, 5'd7);
      wait_rsp(lat);
      n_cmp++; if (rsp_result !== 5'd7) begin n_bad++;
         $display("FAIL midrst_resume: got %0d required 7", rsp_result); end
      ack(1'b0);
      n_cmp++; if (op_count !== exp_ops()) begin n_bad++;
         $display("FAIL midrst_op_count: got %0d required %0d", op_count, exp_ops()); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_shift();
      test_settle3();
      test_check();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_alu_cmd_sequencer
